mem_access_ctrl: RTL and testbench

//  Load/store controller between the EX/MEM pipeline register and the 64-bit byte-addressed data memory.
//  The memory always reads and writes 8 bytes starting at MemAdd. This block adds sub-doubleword accesses:

---
 rtl/mem_access_ctrl_if.sv | 29 ++
 rtl/mem_access_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between the pipeline, mem_access_ctrl and the 64-bit data memory.
// The slave modport is the controller; the master modport is the pipeline plus memory side.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic        stall;
    logic        done;
    logic [63:0] load_data;
    logic        fault;
    logic        dm_MemRead;
    logic        dm_MemWrite;
    logic [63:0] dm_MemAdd;
    logic [63:0] dm_WriteData;
    logic [63:0] dm_ReadData;

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, store_data, dm_ReadData,
        output stall, done, load_data, fault, dm_MemRead, dm_MemWrite, dm_MemAdd, dm_WriteData
    );

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, store_data, dm_ReadData,
        input  stall, done, load_data, fault, dm_MemRead, dm_MemWrite, dm_MemAdd, dm_WriteData
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller: size-extracted loads, read-modify-write for SB/SH/SW, direct SD,
// pipeline stall until completion and a fault flag for misaligned, out-of-range or illegal requests.
module mem_access_ctrl #(
    parameter int MEM_BYTES   = 64,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_addr;
    logic [2:0]  r_funct3;
    logic [63:0] r_store_data;
    logic        r_is_load;
    logic        r_fault;
    logic [63:0] r_word;

    logic        w_req;
    logic        w_bad_op;
    logic        w_range;
    logic        w_misalign;
    logic        w_fault;
    logic [2:0]  w_align_mask;
    logic [64:0] w_end;
    logic [7:0]  w_byte_en;
    logic [63:0] w_merged;
    logic [63:0] w_ext;

    logic        w_stall;
    logic        w_done;
    logic [63:0] w_load_data;
    logic        w_fault_o;
    logic        w_dm_rd;
    logic        w_dm_wr;
    logic [63:0] w_dm_add;
    logic [63:0] w_dm_wdata;

    // Request decode, only meaningful while IDLE
    assign w_req    = bus.req_valid & (bus.mem_read | bus.mem_write);
    assign w_bad_op = (bus.mem_read & bus.mem_write)
                    | (bus.mem_read & (bus.funct3 == 3'd7))
                    | (bus.mem_write & bus.funct3[2]);
    // 65-bit sum so an address near 2^64 cannot wrap into range
    assign w_end    = {1'b0, bus.addr} + 65'd8;
    assign w_range  = w_end > 65'(MEM_BYTES);

    always_comb begin
        w_align_mask = 3'b000;
        case (bus.funct3[1:0])
            2'd0: w_align_mask = 3'b000;
            2'd1: w_align_mask = 3'b001;
            2'd2: w_align_mask = 3'b011;
            2'd3: w_align_mask = 3'b111;
            default: w_align_mask = 3'b000;
        endcase
    end

    assign w_misalign = CHECK_ALIGN && ((bus.addr[2:0] & w_align_mask) != 3'b000);
    assign w_fault    = w_bad_op | w_range | w_misalign;

    // Low size bytes come from the store data, upper bytes from the word just read
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_merge
            assign w_byte_en[gi] = (4'(gi) < (4'd1 << r_funct3[1:0]));
            assign w_merged[gi*8 +: 8] = w_byte_en[gi] ? r_store_data[gi*8 +: 8]
                                                       : bus.dm_ReadData[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        w_ext = '0;
        case (r_funct3)
            3'd0: w_ext = {{56{r_word[7]}},  r_word[7:0]};
            3'd1: w_ext = {{48{r_word[15]}}, r_word[15:0]};
            3'd2: w_ext = {{32{r_word[31]}}, r_word[31:0]};
            3'd3: w_ext = r_word;
            3'd4: w_ext = {56'd0, r_word[7:0]};
            3'd5: w_ext = {48'd0, r_word[15:0]};
            3'd6: w_ext = {32'd0, r_word[31:0]};
            default: w_ext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_fault)
                        w_state_next = S_DONE;
                    else if (bus.mem_read)
                        w_state_next = S_LOAD;
                    else if (bus.funct3[1:0] == 2'd3)
                        w_state_next = S_WRITE;
                    else
                        w_state_next = S_RMW_RD;
                end
            end
            S_LOAD:   w_state_next = S_DONE;
            S_RMW_RD: w_state_next = S_WRITE;
            S_WRITE:  w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // r_word holds the load capture, the merged RMW word, or the SD data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_funct3     <= '0;
            r_store_data <= '0;
            r_is_load    <= 1'b0;
            r_fault      <= 1'b0;
            r_word       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr       <= bus.addr;
                        r_funct3     <= bus.funct3;
                        r_store_data <= bus.store_data;
                        r_is_load    <= bus.mem_read;
                        r_fault      <= w_fault;
                        r_word       <= (bus.mem_write && !w_fault) ? bus.store_data : 64'd0;
                    end
                end
                S_LOAD:   r_word <= bus.dm_ReadData;
                S_RMW_RD: r_word <= w_merged;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_stall     = 1'b0;
        w_done      = 1'b0;
        w_load_data = '0;
        w_fault_o   = 1'b0;
        w_dm_rd     = 1'b0;
        w_dm_wr     = 1'b0;
        w_dm_add    = '0;
        w_dm_wdata  = '0;
        case (r_state)
            S_IDLE: w_stall = w_req;
            S_LOAD, S_RMW_RD: begin
                w_stall  = 1'b1;
                w_dm_rd  = 1'b1;
                w_dm_add = r_addr;
            end
            S_WRITE: begin
                w_stall    = 1'b1;
                w_dm_wr    = 1'b1;
                w_dm_add   = r_addr;
                w_dm_wdata = r_word;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_fault_o   = r_fault;
                w_load_data = (r_is_load && !r_fault) ? w_ext : 64'd0;
            end
            default: ;
        endcase
    end

    assign bus.stall        = w_stall;
    assign bus.done         = w_done;
    assign bus.load_data    = w_load_data;
    assign bus.fault        = w_fault_o;
    assign bus.dm_MemRead   = w_dm_rd;
    assign bus.dm_MemWrite  = w_dm_wr;
    assign bus.dm_MemAdd    = w_dm_add;
    assign bus.dm_WriteData = w_dm_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 64-byte combinational-read data memory model.
module tb_mem_access_ctrl;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [7:0] mem [64];

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.MEM_BYTES(64), .CHECK_ALIGN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.dm_ReadData = '0;
        if (bus.dm_MemAdd <= 64'd56) begin
            for (int k = 0; k < 8; k++)
                bus.dm_ReadData[k*8 +: 8] = mem[int'(bus.dm_MemAdd[5:0]) + k];
        end
    end

    always_ff @(posedge clk) begin
        if (bus.dm_MemWrite && bus.dm_MemAdd <= 64'd56) begin
            for (int k = 0; k < 8; k++)
                mem[int'(bus.dm_MemAdd[5:0]) + k] <= bus.dm_WriteData[k*8 +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: drive, count stall cycles until done, then check the result and the pulse width
    task automatic xact(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] d, input int exp_stall,
                        input logic exp_fault, input logic [63:0] exp_ld, input logic exp_touch);
        int          stalls;
        logic        seen;
        logic        touch;
        logic        flt;
        logic [63:0] ld;
        stalls = 0;
        seen   = 1'b0;
        touch  = 1'b0;
        flt    = 1'b0;
        ld     = '0;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.dm_MemRead || bus.dm_MemWrite) touch = 1'b1;
            if (bus.done) begin
                seen = 1'b1;
                flt  = bus.fault;
                ld   = bus.load_data;
                break;
            end
            if (bus.stall) stalls++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        $display("xact %s rd=%0b wr=%0b f3=%0d addr=%h data=%h -> stalls=%0d fault=%0b load=%h",
                 tag, rd, wr, f3, a, d, stalls, flt, ld);
        check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
        check_eq({tag, "_fault"}, 64'(flt), 64'(exp_fault));
        check_eq({tag, "_load_data"}, ld, exp_ld);
        check_eq({tag, "_mem_touch"}, 64'(touch), 64'(exp_touch));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int n_bad;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[8 + i] = 8'(i + 1);
        mem[16] = 8'h80;
        for (int i = 0; i < 8; i++) mem[i] = 8'hAA;

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.funct3     = 3'd0;
        bus.addr       = '0;
        bus.store_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_stall", 64'(bus.stall), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_fault", 64'(bus.fault), 64'd0);
        check_eq("rst_load_data", bus.load_data, 64'd0);
        check_eq("rst_dm_ctl", {62'd0, bus.dm_MemRead, bus.dm_MemWrite}, 64'd0);
        check_eq("rst_dm_add", bus.dm_MemAdd, 64'd0);
        check_eq("rst_dm_wdata", bus.dm_WriteData, 64'd0);

        xact("lb8",   1, 0, 3'd0, 64'd8,  64'd0, 2, 0, 64'h0000_0000_0000_0001, 1);
        xact("lw8",   1, 0, 3'd2, 64'd8,  64'd0, 2, 0, 64'h0000_0000_0403_0201, 1);
        xact("lhu14", 1, 0, 3'd5, 64'd14, 64'd0, 2, 0, 64'h0000_0000_0000_0807, 1);
        xact("lb16",  1, 0, 3'd0, 64'd16, 64'd0, 2, 0, 64'hFFFF_FFFF_FFFF_FF80, 1);
        xact("lbu16", 1, 0, 3'd4, 64'd16, 64'd0, 2, 0, 64'h0000_0000_0000_0080, 1);
        xact("sh0",   0, 1, 3'd1, 64'd0,  64'h1234, 3, 0, 64'd0, 1);
        xact("ld0",   1, 0, 3'd3, 64'd0,  64'd0, 2, 0, 64'hAAAA_AAAA_AAAA_1234, 1);
        xact("sd56",  0, 1, 3'd3, 64'd56, 64'hDEAD_BEEF_0BAD_F00D, 2, 0, 64'd0, 1);
        xact("ld56",  1, 0, 3'd3, 64'd56, 64'd0, 2, 0, 64'hDEAD_BEEF_0BAD_F00D, 1);
        xact("lw6",   1, 0, 3'd2, 64'd6,  64'd0, 1, 1, 64'd0, 0);
        xact("ld60",  1, 0, 3'd3, 64'd60, 64'd0, 1, 1, 64'd0, 0);
        xact("rdwr",  1, 1, 3'd3, 64'd0,  64'd0, 1, 1, 64'd0, 0);
        xact("lf7",   1, 0, 3'd7, 64'd0,  64'd0, 1, 1, 64'd0, 0);
        xact("sf4",   0, 1, 3'd4, 64'd0,  64'd5, 1, 1, 64'd0, 0);
        xact("sw32",  0, 1, 3'd2, 64'd32, 64'h5566_7788, 3, 0, 64'd0, 1);
        xact("ld32",  1, 0, 3'd3, 64'd32, 64'd0, 2, 0, 64'h0000_0000_5566_7788, 1);

        // req_valid without read or write must be ignored
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.stall || bus.done || bus.dm_MemRead || bus.dm_MemWrite) n_bad++;
        end
        bus.req_valid = 1'b0;
        $display("xact noop req_valid only -> active_cycles=%0d", n_bad);
        check_eq("noop_active", 64'(n_bad), 64'd0);

        // Reset while the SW is in its read phase: nothing may be written and no done appears
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.funct3     = 3'd2;
        bus.addr       = 64'd24;
        bus.store_data = 64'h1122_3344;
        @(posedge clk);
        #1;
        check_eq("abort_in_rmw_rd", 64'(bus.dm_MemRead), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.mem_write  = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.stall || bus.done || bus.dm_MemRead || bus.dm_MemWrite) n_bad++;
        end
        $display("xact sw24 aborted by reset -> active_cycles=%0d", n_bad);
        check_eq("abort_quiet", 64'(n_bad), 64'd0);
        xact("ld24",  1, 0, 3'd3, 64'd24, 64'd0, 2, 0, 64'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
